sm_acc_sequencer: RTL and testbench

Sequences a sign-magnitude accumulation job for one neuron of the pipelined DNN datapath.
- A `start` pulse loads a term count.
- The block accepts that many sign-magnitude products over a valid/ready stream and accumulates them through a combinational sign-magnitude adder.
- It presents the ACC_WIDTH result with a valid/ready handshake to the next pipeline stage (activation/requantise).
- It sits between the multiplier array and the activation stage, one instance per neuron lane.

---
 rtl/sm_acc_pkg.sv | 27 ++
 rtl/sm_acc_add.sv | 52 +++++
 rtl/sm_acc_sequencer.sv | 116 +++++++++++
 tb/tb_sm_acc_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm_acc_pkg.sv
// Shared types, default widths and sign-magnitude helpers for the accumulation sequencer.
package sm_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEF     = 32;
    localparam int ACC_WIDTH_DEF = 34;
    localparam int MAX_TERMS_DEF = 1024;

    localparam int                       SIGN_POS_ACC = ACC_WIDTH_DEF - 1;
    localparam logic [ACC_WIDTH_DEF-2:0] MAG_MAX_ACC  = '1;

    // Helpers take a value right-aligned in 64 bits plus its true width w.
    function automatic logic [63:0] sm_mag(input logic [63:0] v, input int w);
        return v & ((64'd1 << (w - 1)) - 64'd1);
    endfunction

    // A zero magnitude is always positive, so -0 never reads as negative.
    function automatic logic sm_neg(input logic [63:0] v, input int w);
        return (((v >> (w - 1)) & 64'd1) != 64'd0) && (sm_mag(v, w) != 64'd0);
    endfunction

endpackage

// File: rtl/sm_acc_add.sv
// Combinational sign-magnitude add of a narrow term into a wider accumulator.
// Saturates the magnitude on carry-out and never produces -0.
module sm_acc_add
    import sm_acc_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]     term,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 sat
);

    localparam int MW = ACC_WIDTH - 1;

    logic [MW-1:0] a_mag;
    logic [MW-1:0] b_mag;
    logic [MW-1:0] r_mag;
    logic [MW:0]   mag_sum;
    logic          a_neg;
    logic          b_neg;
    logic          r_neg;

    assign a_mag   = MW'(sm_mag(64'(acc), ACC_WIDTH));
    assign b_mag   = MW'(sm_mag(64'(term), WIDTH));
    assign a_neg   = sm_neg(64'(acc), ACC_WIDTH);
    assign b_neg   = sm_neg(64'(term), WIDTH);
    assign mag_sum = {1'b0, a_mag} + {1'b0, b_mag};

    always_comb begin
        sat   = 1'b0;
        r_neg = a_neg;
        r_mag = '0;
        if (a_neg == b_neg) begin
            if (mag_sum[MW]) begin
                r_mag = '1;
                sat   = 1'b1;
            end else begin
                r_mag = mag_sum[MW-1:0];
            end
        end else if (a_mag >= b_mag) begin
            r_mag = a_mag - b_mag;
        end else begin
            r_mag = b_mag - a_mag;
            r_neg = b_neg;
        end
    end

    assign sum = {r_neg && (r_mag != '0), r_mag};

endmodule

// File: rtl/sm_acc_sequencer.sv
// Accumulates len sign-magnitude terms from a valid/ready stream into one result per job.
// Result valid the cycle after the last accepted beat; held stable until out_ready.
module sm_acc_sequencer
    import sm_acc_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     len,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_ovf,
    output logic                 busy
);

    state_t               state;
    state_t               state_nxt;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_sat;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     len_q;
    logic                 ovf_q;
    logic                 beat;

    sm_acc_add #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_add (
        .acc  (acc),
        .term (in_data),
        .sum  (add_sum),
        .sat  (add_sat)
    );

    assign beat = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (cnt + CNT_W'(1) == len_q)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                acc   <= '0;
                cnt   <= '0;
                ovf_q <= 1'b0;
                len_q <= (len > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : len;
            end
        end else if (beat) begin
            acc <= add_sum;
            cnt <= cnt + CNT_W'(1);
            if (add_sat) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Result is exposed only while valid so the bus reads zero otherwise.
    assign out_sum = out_valid ? acc : '0;
    assign out_ovf = out_valid && ovf_q;

endmodule

// File: tb/tb_sm_acc_sequencer.sv
// Randomized and directed checks of sm_acc_sequencer against an integer-arithmetic model.
module tb_sm_acc_sequencer;

    localparam int  MAX_T = 1024;
    localparam longint MAXM = (64'sd1 <<< 33) - 64'sd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] len;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [33:0] out_sum;
    logic        out_ovf;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] terms[$];
    logic [33:0] last_sum;
    logic        last_ovf;

    sm_acc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] sm_enc(input longint v);
        if (v < 0) return {1'b1, 33'(-v)};
        return {1'b0, 33'(v)};
    endfunction

    function automatic longint term_val(input logic [31:0] t);
        longint m;
        m = longint'(t[30:0]);
        return t[31] ? -m : m;
    endfunction

    function automatic logic [31:0] rand_term();
        int unsigned r;
        logic [31:0] t;
        r = $urandom_range(0, 7);
        t = $urandom;
        case (r)
            0:       t = 32'h8000_0000;
            1, 2:    t = {t[31], 31'h7FFF_FFFF};
            default: ;
        endcase
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job: l terms (clamped), vld_pct valid density, hold cycles of out_ready=0.
    task automatic run_job(input int l, input int vld_pct, input int hold);
        int          n;
        int          got_n;
        int          cyc;
        longint      v;
        longint      nv;
        logic        ovf;
        logic        took;
        logic [33:0] exp;
        n = (l > MAX_T) ? MAX_T : l;
        while (terms.size() < n) terms.push_back(rand_term());
        v   = 0;
        ovf = 1'b0;
        start = 1'b1;
        len   = l[10:0];
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        got_n = 0;
        cyc   = 0;
        while (got_n < n && cyc < 4 * n + 50) begin
            in_valid = ($urandom_range(0, 99) < vld_pct);
            in_data  = in_valid ? terms[got_n] : $urandom;
            start    = ($urandom_range(0, 3) == 0);
            len      = 11'($urandom_range(1, 5));
            chk("accum_hs", {in_ready, out_valid}, 2'b10);
            took = in_valid;
            tick();
            if (took) begin
                nv = v + term_val(terms[got_n]);
                if (nv > MAXM) begin nv = MAXM; ovf = 1'b1; end
                if (nv < -MAXM) begin nv = -MAXM; ovf = 1'b1; end
                v = nv;
                got_n++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("accum_count", got_n, n);
        terms.delete();
        exp = sm_enc(v);
        chk("done_valid", out_valid, 1);
        chk("done_in_ready", in_ready, 0);
        chk("done_sum", out_sum, exp);
        chk("done_ovf", out_ovf, ovf);
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            len   = 11'd1;
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, exp);
            chk("hold_ovf", out_ovf, ovf);
        end
        last_sum  = out_sum;
        last_ovf  = out_ovf;
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; clear = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        chk("rst_outs", {in_ready, out_valid, out_ovf, busy}, 0);
        chk("rst_sum", out_sum, 0);
        tick();
        rst = 1'b0;
        tick();

        terms = '{32'h0000_0005, 32'h8000_0003, 32'h0000_0007};
        run_job(3, 100, 0);
        chk("basic_sum", last_sum, 34'h0_0000_0009);
        chk("basic_ovf", last_ovf, 0);

        terms = '{32'h8000_0004, 32'h0000_0004};
        run_job(2, 100, 0);
        chk("cancel_sum", last_sum, 0);

        run_job(0, 100, 1);
        chk("len0_sum", last_sum, 0);

        terms = '{32'h1, 32'h1, 32'h1, 32'h1};
        run_job(4, 50, 5);
        chk("bp_sum", last_sum, 34'h4);

        terms = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        run_job(5, 100, 0);
        chk("sat_sum", last_sum, 34'h1_FFFF_FFFF);
        chk("sat_ovf", last_ovf, 1);
        terms = '{32'h0000_0002};
        run_job(1, 100, 0);
        chk("post_sat_ovf", last_ovf, 0);

        // Abort after two of four beats, with a beat offered alongside clear.
        start = 1'b1; len = 11'd4;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0009;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("abort_state", {busy, in_ready, out_valid}, 0);
        terms = '{32'h8000_0002};
        run_job(1, 100, 0);
        chk("abort_next_sum", last_sum, 34'h2_0000_0002);

        run_job(1500, 90, 0);

        // Async reset between edges, once mid-ACCUM and once with a result pending.
        start = 1'b1; len = 11'd4;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0003;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_accum", {busy, in_ready, out_valid, out_ovf}, 0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1; len = 11'd1;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0005;
        tick();
        in_valid = 1'b0;
        chk("arst_pre_sum", out_sum, 34'h5);
        #2 rst = 1'b1;
        #1;
        chk("arst_done_sum", out_sum, 0);
        chk("arst_done_flags", {busy, out_valid}, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int j = 0; j < 25; j++) begin
            run_job($urandom_range(1, 40), $urandom_range(30, 100), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
